// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package core_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new entry, hold, or collapse into a bubble.
import core_pkg::*;

module if_id_reg (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg.instr    <= NOP_INSTR;
            q_reg.pc       <= 32'h0;
            q_reg.pc_plus4 <= 32'h0;
            q_reg.valid    <= 1'b0;
        end else if (bubble) begin
            // A bubble keeps the old PC fields so debug views stay meaningful.
            q_reg.instr <= NOP_INSTR;
            q_reg.valid <= 1'b0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, fault detection, halt FSM and IF/ID capture.
import core_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rd,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc_plus4,
    output logic        o_if_valid,
    output logic        o_fault,
    output logic [31:0] o_fault_pc,
    output logic [31:0] o_fetch_count
);

    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         fault_reg, fault_next;
    logic [31:0]  fault_pc_reg, fault_pc_next;
    logic [31:0]  count_reg, count_next;
    logic [31:0]  pc_plus4;
    logic         fault_cond;
    logic         ifid_load;
    logic         ifid_bubble;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign pc_plus4   = pc_reg + 32'd4;
    assign fault_cond = (pc_reg[1:0] != 2'b00) || (pc_reg >= PC_LIMIT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= FS_RUN;
            pc_reg       <= RESET_PC;
            fault_reg    <= 1'b0;
            fault_pc_reg <= 32'h0;
            count_reg    <= 32'h0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
            count_reg    <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        count_next    = count_reg;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;
        case (state_reg)
            FS_RUN: begin
                if (fault_cond) begin
                    state_next    = FS_HALT;
                    fault_next    = 1'b1;
                    fault_pc_next = pc_reg;
                    ifid_bubble   = 1'b1;
                end else if (i_redirect) begin
                    pc_next     = i_redirect_pc;
                    ifid_bubble = 1'b1;
                end else if (i_stall) begin
                    // Stall holds IF/ID unless a flush arrives alongside it.
                    ifid_bubble = i_flush;
                end else if (i_flush) begin
                    pc_next     = pc_plus4;
                    ifid_bubble = 1'b1;
                end else begin
                    pc_next    = pc_plus4;
                    ifid_load  = 1'b1;
                    count_next = count_reg + 32'd1;
                end
            end
            FS_HALT: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_next  = FS_HALT;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    always_comb begin
        ifid_d.instr    = i_imem_rd;
        ifid_d.pc       = pc_reg;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.valid    = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk    (i_clk),
        .rst    (i_rst),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign o_imem_addr   = pc_reg;
    assign o_if_instr    = ifid_q.instr;
    assign o_if_pc       = ifid_q.pc;
    assign o_if_pc_plus4 = ifid_q.pc_plus4;
    assign o_if_valid    = ifid_q.valid;
    assign o_fault       = fault_reg;
    assign o_fault_pc    = fault_pc_reg;
    assign o_fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch order, stall/flush, redirect, faults, async reset.
module tb_fetch_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall;
    logic        i_flush;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rd;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_pc_plus4;
    logic        o_if_valid;
    logic        o_fault;
    logic [31:0] o_fault_pc;
    logic [31:0] o_fetch_count;

    logic [31:0] mem [0:127];
    int          total  = 0;
    int          passed = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rd     (i_imem_rd),
        .o_if_instr    (o_if_instr),
        .o_if_pc       (o_if_pc),
        .o_if_pc_plus4 (o_if_pc_plus4),
        .o_if_valid    (o_if_valid),
        .o_fault       (o_fault),
        .o_fault_pc    (o_fault_pc),
        .o_fetch_count (o_fetch_count)
    );

    always #5 i_clk = ~i_clk;

    // Asynchronous-read memory: word i holds 0xC0DE_00ii.
    always_comb begin
        if (o_imem_addr < 32'd512) i_imem_rd = mem[o_imem_addr[8:2]];
        else                       i_imem_rd = 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        $display("t=%0t addr=%08h instr=%08h pc=%08h valid=%0b fault=%0b fpc=%08h cnt=%0d",
                 $time, o_imem_addr, o_if_instr, o_if_pc, o_if_valid, o_fault, o_fault_pc, o_fetch_count);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc, input logic valid, input logic [31:0] cnt);
        check({tag, ".addr"},  o_imem_addr, addr);
        check({tag, ".instr"}, o_if_instr, instr);
        check({tag, ".pc"},    o_if_pc, pc);
        check({tag, ".valid"}, {31'h0, o_if_valid}, {31'h0, valid});
        check({tag, ".cnt"},   o_fetch_count, cnt);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = {16'hC0DE, 16'(i)};
        i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        #2;
        check_ifid("reset", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
        check("reset.pc4",   o_if_pc_plus4, 32'h0);
        check("reset.fault", {31'h0, o_fault}, 32'h0);
        check("reset.fpc",   o_fault_pc, 32'h0);
        @(negedge i_clk); i_rst = 1'b0;

        // Sequential fetch A, B
        step(); check_ifid("seq1", 32'h4, 32'hC0DE_0000, 32'h0, 1'b1, 32'd1);
        check("seq1.pc4", o_if_pc_plus4, 32'h4);
        step(); check_ifid("seq2", 32'h8, 32'hC0DE_0001, 32'h4, 1'b1, 32'd2);

        // Two-cycle stall at PC=8
        i_stall = 1'b1;
        step(); check_ifid("stall1", 32'h8, 32'hC0DE_0001, 32'h4, 1'b1, 32'd2);
        step(); check_ifid("stall2", 32'h8, 32'hC0DE_0001, 32'h4, 1'b1, 32'd2);
        i_stall = 1'b0;
        step(); check_ifid("unstall", 32'hC, 32'hC0DE_0002, 32'h8, 1'b1, 32'd3);
        check("unstall.pc4", o_if_pc_plus4, 32'hC);

        // Stall with flush: PC holds, IF/ID bubbles, PC fields kept
        i_stall = 1'b1; i_flush = 1'b1;
        step(); check_ifid("stflush", 32'hC, NOP, 32'h8, 1'b0, 32'd3);
        check("stflush.pc4", o_if_pc_plus4, 32'hC);
        i_stall = 1'b0;

        // Flush alone: PC advances, bubble
        step(); check_ifid("flush", 32'h10, NOP, 32'h8, 1'b0, 32'd3);
        i_flush = 1'b0;
        step(); check_ifid("after_flush", 32'h14, 32'hC0DE_0004, 32'h10, 1'b1, 32'd4);

        // Redirect together with stall to 0x40
        i_redirect = 1'b1; i_redirect_pc = 32'h40; i_stall = 1'b1;
        step(); check_ifid("redir", 32'h40, NOP, 32'h10, 1'b0, 32'd4);
        i_redirect = 1'b0; i_stall = 1'b0;
        step(); check_ifid("redir_tgt", 32'h44, 32'hC0DE_0010, 32'h40, 1'b1, 32'd5);

        // Misaligned redirect 0x42 -> HALT
        i_redirect = 1'b1; i_redirect_pc = 32'h42;
        step(); check_ifid("mis_redir", 32'h42, NOP, 32'h40, 1'b0, 32'd5);
        check("mis_redir.fault", {31'h0, o_fault}, 32'h0);
        i_redirect = 1'b0;
        step(); check_ifid("halt", 32'h42, NOP, 32'h40, 1'b0, 32'd5);
        check("halt.fault", {31'h0, o_fault}, 32'h1);
        check("halt.fpc",   o_fault_pc, 32'h42);
        i_redirect = 1'b1; i_redirect_pc = 32'h80;
        step(); check_ifid("halt_ign", 32'h42, NOP, 32'h40, 1'b0, 32'd5);
        check("halt_ign.fpc", o_fault_pc, 32'h42);
        i_redirect = 1'b0;

        // Reset clears HALT asynchronously
        @(negedge i_clk); i_rst = 1'b1; #1;
        check("rst_halt.fault", {31'h0, o_fault}, 32'h0);
        check("rst_halt.addr",  o_imem_addr, 32'h0);
        check("rst_halt.cnt",   o_fetch_count, 32'h0);
        @(negedge i_clk); i_rst = 1'b0;
        step(); check_ifid("restart", 32'h4, 32'hC0DE_0000, 32'h0, 1'b1, 32'd1);

        // Run off the end of memory from 0x1F8
        i_redirect = 1'b1; i_redirect_pc = 32'h1F8;
        step(); check("end.addr0", o_imem_addr, 32'h1F8);
        i_redirect = 1'b0;
        step(); check_ifid("end1", 32'h1FC, 32'hC0DE_007E, 32'h1F8, 1'b1, 32'd2);
        step(); check_ifid("end2", 32'h200, 32'hC0DE_007F, 32'h1FC, 1'b1, 32'd3);
        step(); check_ifid("end_fault", 32'h200, NOP, 32'h1FC, 1'b0, 32'd3);
        check("end_fault.fault", {31'h0, o_fault}, 32'h1);
        check("end_fault.fpc",   o_fault_pc, 32'h200);

        // Reset pulsed between edges during a pending redirect
        @(negedge i_clk); i_rst = 1'b1;
        @(negedge i_clk); i_rst = 1'b0;
        step(); check("pre_rr.addr", o_imem_addr, 32'h4);
        i_redirect = 1'b1; i_redirect_pc = 32'h40;
        #3; i_rst = 1'b1; #1;
        check_ifid("rst_redir", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
        check("rst_redir.pc4", o_if_pc_plus4, 32'h0);
        @(negedge i_clk); i_redirect = 1'b0; i_rst = 1'b0;
        step(); check_ifid("post_rr", 32'h4, 32'hC0DE_0000, 32'h0, 1'b1, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Owns the program counter, drives the word-aligned fetch address into the asynchronous-read instruction memory, and registers the returned instruction with its PC into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect, and fetch-fault detection (misaligned or out-of-range PC). It sits between the hazard/branch logic and the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `IMEM_WORDS`, default 128: instruction memory depth in 32-bit words. The legal byte range is 0 to 4*IMEM_WORDS-1.
- `i_clk`, input, 1: single clock. All state updates on the rising edge.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_stall`, input, 1: hold the PC and the IF/ID register.
- `i_flush`, input, 1: insert a bubble into IF/ID.
- `i_redirect`, input, 1: load `i_redirect_pc` as the next PC (taken branch or jump).
- `i_redirect_pc`, input, 32: redirect target, byte address.
- `o_imem_addr`, output, 32: fetch byte address. Always equals the current PC.
- `i_imem_rd`, input, 32: instruction word from memory. Combinational response to `o_imem_addr`.
- `o_if_instr`, output, 32: IF/ID instruction.
- `o_if_pc`, output, 32: IF/ID PC.
- `o_if_pc_plus4`, output, 32: IF/ID PC+4.
- `o_if_valid`, output, 1: IF/ID holds a real instruction.
- `o_fault`, output, 1: sticky fetch fault.
- `o_fault_pc`, output, 32: PC that caused the fault.
- `o_fetch_count`, output, 32: number of instructions captured into IF/ID.

## Operation
- FSM has two states:
  - RUN: normal fetch.
  - HALT: entered on a fetch fault; left only by reset.
- Fault condition, evaluated on the current PC in RUN: `pc[1:0] != 0`, or `pc >= 4*IMEM_WORDS` (32-bit unsigned compare).
- Next-state priority in RUN, per edge:
  1. Fault: go to HALT. Set `o_fault` and latch `o_fault_pc = pc`. IF/ID becomes a bubble. PC holds. Fault takes priority over redirect, stall and flush in the same cycle.
  2. `i_redirect`: PC <= `i_redirect_pc`; IF/ID becomes a bubble. Redirect overrides `i_stall` and `i_flush`.
  3. `i_stall`: PC holds. IF/ID holds, except that `i_flush` together with stall clears `o_if_valid` and loads NOP (flush wins for IF/ID).
  4. `i_flush` alone: PC <= PC+4; IF/ID becomes a bubble.
  5. Otherwise: PC <= PC+4. IF/ID <= {`i_imem_rd`, PC, PC+4, valid=1}. `o_fetch_count` increments.
- Bubble contents: `o_if_instr` = NOP 32'h0000_0013, `o_if_valid` = 0. `o_if_pc` and `o_if_pc_plus4` keep their previous values.
- In HALT:
  - PC, `o_fault_pc` and `o_fetch_count` are frozen.
  - `o_if_valid` = 0 and `o_if_instr` = NOP.
  - `i_redirect`, `i_stall` and `i_flush` are ignored.
- PC+4 is a 32-bit add that wraps at 2^32. A wrapped PC is caught by the range check.
- `o_fetch_count` wraps from 2^32-1 to 0.
- A `RESET_PC` outside the legal range faults on the first edge after reset release.

## Timing
- `o_imem_addr` is combinational from the PC register. There is no logic between it and the memory.
- An instruction at PC P appears on `o_if_*` one edge after P is driven. Throughput is one instruction per cycle when not stalled.
- Redirect costs one bubble: on the edge where redirect is sampled, IF/ID gets a bubble and the PC takes the target. The target instruction is valid on the following edge.
- Reset values, applied asynchronously while `i_rst` is high:
  - PC = `RESET_PC`, so `o_imem_addr` = `RESET_PC`.
  - FSM = RUN.
  - `o_if_instr` = 32'h0000_0013, `o_if_pc` = 0, `o_if_pc_plus4` = 0, `o_if_valid` = 0.
  - `o_fault` = 0, `o_fault_pc` = 0, `o_fetch_count` = 0.
- Reset asserted mid-stall, mid-redirect or in HALT discards all state immediately. Fetch resumes from `RESET_PC` on the first edge after release.

## Structure
- Package `core_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - `fetch_state_t` enum {FS_RUN, FS_HALT}.
  - `if_id_t` packed struct {instr, pc, pc_plus4, valid}.
- Sub-module `if_id_reg`: the IF/ID register, with async reset, load/hold/bubble controls and `if_id_t` ports.
- `fetch_stage` contains the PC register, FSM, fault check, counter and priority logic.

## Test plan
- Reset release with memory words 0..3 = A,B,C,D and no stall: `o_imem_addr` is 0,4,8,12 on successive cycles; `o_if_instr` is NOP,A,B,C with valid 0,1,1,1; `o_fetch_count` = 3 after the third capture.
- Stall asserted for 2 cycles while PC=8: PC stays 8; IF/ID holds B (pc=4, valid=1); the counter does not advance; C is captured on the cycle after release.
- `i_redirect` together with `i_stall`, target 0x40: next PC = 0x40; IF/ID is a bubble (valid=0, instr 0x13); the instruction at 0x40 is valid one edge later.
- Redirect to 0x42: the next edge enters HALT with `o_fault` = 1 and `o_fault_pc` = 0x42; valid stays 0; later redirects are ignored. Asserting `i_rst` clears the fault and restarts at `RESET_PC`.
- Sequential run from 0x1F8 with `IMEM_WORDS` = 128: 0x1F8 and 0x1FC are captured; PC = 0x200 then faults with `o_fault_pc` = 0x200.
- `i_rst` pulsed asynchronously between edges during a redirect: outputs show reset values immediately; the PC after release is `RESET_PC`, not the redirect target.
